// File: rtl/lfu_replacement_ctrl.sv
// LFU replacement controller for a 4-way set-associative cache.
// Reads per-set counters, picks a victim on a miss, then updates the bank.
module lfu_replacement_ctrl #(
    parameter int BITS_DIRECT  = 10,
    parameter int SIZE_COUNTER = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    access_valid,
    output logic                    access_ready,
    input  logic [BITS_DIRECT-1:0]  address,
    input  logic                    hit,
    input  logic [3:0]              hit_way,
    input  logic [3:0]              way_valid,
    input  logic                    flush,
    output logic                    done,
    output logic [3:0]              victim_way,
    output logic                    was_hit,
    output logic                    cnt_enable,
    output logic [3:0]              cnt_line_reset,
    output logic [3:0]              cnt_line_sum,
    output logic [BITS_DIRECT-1:0]  cnt_address,
    output logic                    cnt_read,
    output logic                    cnt_gen_reset,
    input  logic [SIZE_COUNTER-1:0] count_in0,
    input  logic [SIZE_COUNTER-1:0] count_in1,
    input  logic [SIZE_COUNTER-1:0] count_in2,
    input  logic [SIZE_COUNTER-1:0] count_in3
);

    localparam logic [SIZE_COUNTER-1:0] CMAX = '1;

    typedef enum logic [2:0] {
        IDLE, FLUSH, READ, CMP, UPDATE, FILL, DONE
    } state_t;

    state_t                   state;
    logic [BITS_DIRECT-1:0]   addr_q;
    logic [3:0]               hit_way_q;
    logic [3:0]               way_valid_q;
    logic [SIZE_COUNTER-1:0]  cnt [4];
    logic [SIZE_COUNTER-1:0]  hit_cnt;
    logic [3:0]               next_victim;

    assign cnt[0] = count_in0;
    assign cnt[1] = count_in1;
    assign cnt[2] = count_in2;
    assign cnt[3] = count_in3;

    assign access_ready = (state == IDLE) && !flush;

    // Counter of the hit way, selected by the one-hot latched hit vector
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            if (hit_way_q[i]) hit_cnt = hit_cnt | cnt[i];
        end
    end

    // Victim choice: hit way, else lowest invalid way, else lowest-index minimum count
    always_comb begin
        logic [1:0]              min_idx;
        logic [SIZE_COUNTER-1:0] min_val;
        logic                    found;
        next_victim = '0;
        min_idx     = 2'd0;
        min_val     = cnt[0];
        found       = 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (cnt[i] < min_val) begin
                min_val = cnt[i];
                min_idx = 2'(i);
            end
        end
        if (was_hit) begin
            next_victim = hit_way_q;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!found && !way_valid_q[i]) begin
                    next_victim[i] = 1'b1;
                    found          = 1'b1;
                end
            end
            if (!found) next_victim[min_idx] = 1'b1;
        end
    end

    // Main FSM with registered strobes and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            addr_q         <= '0;
            was_hit        <= 1'b0;
            hit_way_q      <= '0;
            way_valid_q    <= '0;
            victim_way     <= '0;
            done           <= 1'b0;
            cnt_enable     <= 1'b0;
            cnt_line_reset <= '0;
            cnt_line_sum   <= '0;
            cnt_address    <= '0;
            cnt_read       <= 1'b0;
            cnt_gen_reset  <= 1'b0;
        end else begin
            done           <= 1'b0;
            cnt_enable     <= 1'b0;
            cnt_line_reset <= '0;
            cnt_line_sum   <= '0;
            cnt_address    <= '0;
            cnt_read       <= 1'b0;
            cnt_gen_reset  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (flush) begin
                        cnt_gen_reset <= 1'b1;
                        state         <= FLUSH;
                    end else if (access_valid) begin
                        addr_q      <= address;
                        was_hit     <= hit;
                        hit_way_q   <= hit_way;
                        way_valid_q <= way_valid;
                        cnt_read    <= 1'b1;
                        cnt_address <= address;
                        state       <= READ;
                    end
                end
                FLUSH: state <= IDLE;
                READ:  state <= CMP;
                CMP: begin
                    victim_way <= next_victim;
                    state      <= UPDATE;
                    if (was_hit) begin
                        // A saturated counter holds rather than wrapping
                        if (hit_cnt != CMAX) begin
                            cnt_enable   <= 1'b1;
                            cnt_line_sum <= hit_way_q;
                            cnt_address  <= addr_q;
                        end
                    end else begin
                        cnt_enable     <= 1'b1;
                        cnt_line_reset <= next_victim;
                        cnt_address    <= addr_q;
                    end
                end
                UPDATE: begin
                    if (was_hit) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt_enable   <= 1'b1;
                        cnt_line_sum <= victim_way;
                        cnt_address  <= addr_q;
                        state        <= FILL;
                    end
                end
                FILL: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
